umi_xbar_rr: RTL and testbench
==============================

# umi_xbar_rr

Parametrised NI-input, NO-output UMI crossbar. Each output has a fair round-robin arbiter, a one-entry registered output stage and full-throughput handshakes. Routing decodes a configurable dstaddr field. Packets with out-of-range destinations are dropped and flagged. It replaces the fixed-mode, request-vector crossbar in the host/device fabric and is the block wired between per-port UMI agents.

## Interface
- NI, 4: number of input ports (>=2)
- NO, 4: number of output ports (>=1)
- CW, 32: command width
- AW, 64: address width
- DW, 256: data width
- RLSB, 40: LSB of the route field in dstaddr
- RW, 16: route field width; destination = dstaddr[RLSB+:RW]
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- mask  in  NI*NO  bit j*NI+i set blocks input i from output j; the packet waits and is not dropped
- umi_in_valid  in  NI  per-input valid
- umi_in_ready  out  NI  per-input ready
- umi_in_cmd / umi_in_dstaddr / umi_in_srcaddr / umi_in_data  in  NI*CW / NI*AW / NI*AW / NI*DW  packed per-input fields, port i at [i*W+:W]
- umi_out_valid  out  NO  per-output valid, registered
- umi_out_ready  in  NO  per-output ready
- umi_out_cmd / umi_out_dstaddr / umi_out_srcaddr / umi_out_data  out  NO*CW / NO*AW / NO*AW / NO*DW  registered output fields
- err_route  out  NI  sticky: input i presented a destination >= NO

## Operation
- Decode: dest_i = dstaddr_i[RLSB+:RW].
- req[j][i] = valid_i & (dest_i == j) & ~mask[j*NI+i].
- Out-of-range (dest_i >= NO): umi_in_ready[i]=1 combinationally, so the packet is consumed. It is not forwarded. err_route[i] is set on that cycle's edge.
- Each output j has a holding register (valid, cmd, dstaddr, srcaddr, data).
- can_load_j = ~out_valid_j | umi_out_ready[j].
- Arbiter j: a pointer ptr_j in [0,NI-1]. It scans inputs ptr_j, ptr_j+1, … mod NI and grants the first requester.
- Grant is effective only when can_load_j.
- umi_in_ready[i] = 1 iff input i is granted at its destination output and that output can load, or iff the packet is dropped.
- On effective grant to input k:
  - the register loads input k's fields;
  - out_valid_j is set;
  - ptr_j becomes (k+1) mod NI.
- Without an effective grant, ptr_j holds.
- If umi_out_ready[j] & out_valid_j and no new grant, out_valid_j clears.
- Fields are not cleared; they hold their last value.
- Handshakes:
  - transfer occurs when valid & ready in the same cycle;
  - ready depends on valid; valid never depends on ready;
  - a stalled output holds its fields stable.
- Outputs are independent: different outputs may accept different inputs in the same cycle.
- An input targets exactly one output, so it never gets two grants.
- err_route bits are sticky until reset.

## Timing
- Reset, applied on a rising edge with reset=1:
  - out_valid=0, all ptr=0, err_route=0;
  - output data registers reset to 0.
- While reset=1, umi_in_ready=0 regardless of inputs.
- The first accept is possible in the cycle after reset deasserts.
- Latency: an input accepted in cycle t appears on umi_out_* in cycle t+1.
- Throughput: one packet per output per cycle while umi_out_ready stays high. Load and unload happen in the same cycle.
- Backpressure: out_valid=1 & out_ready=0 → can_load=0. All requesters to that output see ready=0 and the pointer freezes.
- Fairness: with all NI inputs continuously requesting one output, each is granted exactly once every NI transfers.
- Reset mid-operation: held packets are discarded, out_valid drops the next edge, and pointers and errors clear.

## Test plan
- Single transfer, NI=NO=4:
  - stimulus: input 2 sends dstaddr route=1, cmd=0x5, data=0xAB, with out_ready[1]=1;
  - response: in_ready[2]=1 in cycle t, out_valid[1]=1 in t+1 with identical fields, other outputs idle.
- Round-robin contention:
  - stimulus: inputs 0, 1 and 3 hold valid to output 0 for 6 packets each, out_ready=1;
  - response: grant order 0,1,3,0,1,3,…; one packet per cycle, no bubbles.
- Backpressure:
  - stimulus: out_ready[2]=0 for 5 cycles with 2 inputs pending;
  - response: out_valid[2] stays 1 with stable fields, in_ready low, pointer frozen;
  - on release, the next input in order after the held packet's grantee is accepted and the register reloads in the same cycle.
- Out-of-range destination:
  - stimulus: input 1 sends route=7 with NO=4;
  - response: accepted immediately, no out_valid anywhere, err_route=4'b0010 from the next cycle on.
- Mask plus parallel routes:
  - stimulus: mask input 0→output 3, with 0→3, 1→2 and 2→1 pending;
  - response: 1→2 and 2→1 transfer in the same cycle, 0 waits;
  - clearing the mask transfers 0→3 the next cycle.
- Reset mid-stream:
  - stimulus: assert reset for 1 cycle during the contention test;
  - response: all out_valid=0, err_route=0, in_ready=0 during reset;
  - next grant goes to the lowest requesting index.

Source files
------------

// File: rtl/umi_xbar_rr.sv
// -----------------------------------------------------------------------------
// umi_xbar_rr
//
// NI-input / NO-output UMI crossbar. Every input decodes a route field from its
// dstaddr and requests exactly one output. Every output has a round-robin
// arbiter and a one-entry registered output stage. Grants, loads and unloads
// all happen in the same cycle, so throughput is one packet per output per
// cycle. A packet whose route is >= NO is consumed at once, is never forwarded,
// and sets a sticky err_route bit for its input.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   mask            bit j*NI+i set blocks input i from output j (packet waits)
//   umi_in_valid    per-input valid
//   umi_in_ready    per-input ready (combinational, forced low while in reset)
//   umi_in_cmd      packed per-input command,  port i at [i*CW+:CW]
//   umi_in_dstaddr  packed per-input dstaddr,  port i at [i*AW+:AW]
//   umi_in_srcaddr  packed per-input srcaddr,  port i at [i*AW+:AW]
//   umi_in_data     packed per-input data,     port i at [i*DW+:DW]
//   umi_out_valid   per-output valid (registered)
//   umi_out_ready   per-output ready
//   umi_out_cmd     registered per-output command, port j at [j*CW+:CW]
//   umi_out_dstaddr registered per-output dstaddr
//   umi_out_srcaddr registered per-output srcaddr
//   umi_out_data    registered per-output data
//   err_route       sticky per-input flag: a route >= NO was presented
// -----------------------------------------------------------------------------
module umi_xbar_rr #(
  parameter int NI   = 4,
  parameter int NO   = 4,
  parameter int CW   = 32,
  parameter int AW   = 64,
  parameter int DW   = 256,
  parameter int RLSB = 40,
  parameter int RW   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NI*NO-1:0] mask,
  input  logic [NI-1:0]    umi_in_valid,
  output logic [NI-1:0]    umi_in_ready,
  input  logic [NI*CW-1:0] umi_in_cmd,
  input  logic [NI*AW-1:0] umi_in_dstaddr,
  input  logic [NI*AW-1:0] umi_in_srcaddr,
  input  logic [NI*DW-1:0] umi_in_data,
  output logic [NO-1:0]    umi_out_valid,
  input  logic [NO-1:0]    umi_out_ready,
  output logic [NO*CW-1:0] umi_out_cmd,
  output logic [NO*AW-1:0] umi_out_dstaddr,
  output logic [NO*AW-1:0] umi_out_srcaddr,
  output logic [NO*DW-1:0] umi_out_data,
  output logic [NI-1:0]    err_route
);

  localparam int PW = (NI > 1) ? $clog2(NI) : 1;
  // One extra bit so ptr + offset never overflows before the modulo fold.
  localparam logic [PW:0] NI_W = (PW+1)'(NI);
  localparam logic [RW:0] NO_W = (RW+1)'(NO);

  typedef logic [PW-1:0] ptr_t;

  // Per-port views of the packed input buses.
  logic [NI-1:0][CW-1:0] in_cmd_s;
  logic [NI-1:0][AW-1:0] in_dst_s;
  logic [NI-1:0][AW-1:0] in_src_s;
  logic [NI-1:0][DW-1:0] in_data_s;

  assign in_cmd_s  = umi_in_cmd;
  assign in_dst_s  = umi_in_dstaddr;
  assign in_src_s  = umi_in_srcaddr;
  assign in_data_s = umi_in_data;

  // Decode / arbitration signals.
  logic [NI-1:0][RW-1:0] dest_s;
  logic [NI-1:0]         drop_s;
  logic [NO-1:0][NI-1:0] req_s;
  logic [NO-1:0]         can_load_s;
  logic [NO-1:0]         gnt_vld_s;
  ptr_t [NO-1:0]         gnt_idx_s;
  logic [NO-1:0]         eff_s;
  logic [PW:0]           scan_s;
  logic [PW:0]           nxt_s;
  logic [NI-1:0]         acc_s;

  // State.
  logic [NO-1:0]         valid_q, valid_d;
  ptr_t [NO-1:0]         ptr_q, ptr_d;
  logic [NI-1:0]         err_q, err_d;
  logic [NO-1:0][CW-1:0] cmd_q;
  logic [NO-1:0][AW-1:0] dst_q;
  logic [NO-1:0][AW-1:0] src_q;
  logic [NO-1:0][DW-1:0] data_q;

  assign umi_out_valid   = valid_q;
  assign umi_out_cmd     = cmd_q;
  assign umi_out_dstaddr = dst_q;
  assign umi_out_srcaddr = src_q;
  assign umi_out_data    = data_q;
  assign err_route       = err_q;

  // Route decode: per-output request matrix and out-of-range drop detection.
  always_comb begin
    dest_s = '0;
    drop_s = '0;
    req_s  = '0;
    for (int i = 0; i < NI; i++) begin
      dest_s[i] = in_dst_s[i][RLSB +: RW];
      drop_s[i] = umi_in_valid[i] & ({1'b0, dest_s[i]} >= NO_W);
      for (int j = 0; j < NO; j++) begin
        req_s[j][i] = umi_in_valid[i]
                    & ({1'b0, dest_s[i]} == (RW+1)'(j))
                    & ~mask[j*NI+i];
      end
    end
  end

  // Per-output round-robin scan starting at ptr, plus next pointer/valid.
  always_comb begin
    can_load_s = '0;
    gnt_vld_s  = '0;
    gnt_idx_s  = '0;
    eff_s      = '0;
    scan_s     = '0;
    nxt_s      = '0;
    ptr_d      = ptr_q;
    valid_d    = valid_q;
    for (int j = 0; j < NO; j++) begin
      can_load_s[j] = ~valid_q[j] | umi_out_ready[j];
      for (int off = 0; off < NI; off++) begin
        scan_s = {1'b0, ptr_q[j]} + (PW+1)'(off);
        if (scan_s >= NI_W) begin
          scan_s = scan_s - NI_W;
        end else begin
          scan_s = scan_s;
        end
        if (!gnt_vld_s[j] && req_s[j][scan_s[PW-1:0]]) begin
          gnt_vld_s[j] = 1'b1;
          gnt_idx_s[j] = scan_s[PW-1:0];
        end else begin
          gnt_vld_s[j] = gnt_vld_s[j];
        end
      end
      // A grant only counts when the holding register can take it.
      eff_s[j] = gnt_vld_s[j] & can_load_s[j] & ~reset;
      nxt_s    = {1'b0, gnt_idx_s[j]} + (PW+1)'(1);
      if (nxt_s >= NI_W) begin
        nxt_s = '0;
      end else begin
        nxt_s = nxt_s;
      end
      if (eff_s[j]) begin
        ptr_d[j]   = nxt_s[PW-1:0];
        valid_d[j] = 1'b1;
      end else if (umi_out_ready[j]) begin
        ptr_d[j]   = ptr_q[j];
        valid_d[j] = 1'b0;
      end else begin
        ptr_d[j]   = ptr_q[j];
        valid_d[j] = valid_q[j];
      end
    end
  end

  // Input ready (granted-and-loadable or dropped) and sticky error update.
  always_comb begin
    acc_s = '0;
    for (int i = 0; i < NI; i++) begin
      for (int j = 0; j < NO; j++) begin
        if (eff_s[j] && (gnt_idx_s[j] == ptr_t'(i))) begin
          acc_s[i] = 1'b1;
        end else begin
          acc_s[i] = acc_s[i];
        end
      end
    end
    if (reset) begin
      umi_in_ready = '0;
      err_d        = '0;
    end else begin
      umi_in_ready = acc_s | drop_s;
      err_d        = err_q | drop_s;
    end
  end

  // State registers and the per-output holding stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      ptr_q   <= '0;
      err_q   <= '0;
      cmd_q   <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      for (int j = 0; j < NO; j++) begin
        if (eff_s[j]) begin
          cmd_q[j]  <= in_cmd_s[gnt_idx_s[j]];
          dst_q[j]  <= in_dst_s[gnt_idx_s[j]];
          src_q[j]  <= in_src_s[gnt_idx_s[j]];
          data_q[j] <= in_data_s[gnt_idx_s[j]];
        end
      end
    end
  end

endmodule

// File: tb/tb_umi_xbar_rr.sv
module tb_umi_xbar_rr;

  localparam int NI   = 4;
  localparam int NO   = 4;
  localparam int CW   = 32;
  localparam int AW   = 64;
  localparam int DW   = 256;
  localparam int RLSB = 40;
  localparam int RW   = 16;
  localparam int FW   = CW + 2*AW + DW;

  logic             clk;
  logic             reset;
  logic [NI*NO-1:0] mask;
  logic [NI-1:0]    umi_in_valid;
  logic [NI-1:0]    umi_in_ready;
  logic [NI*CW-1:0] umi_in_cmd;
  logic [NI*AW-1:0] umi_in_dstaddr;
  logic [NI*AW-1:0] umi_in_srcaddr;
  logic [NI*DW-1:0] umi_in_data;
  logic [NO-1:0]    umi_out_valid;
  logic [NO-1:0]    umi_out_ready;
  logic [NO*CW-1:0] umi_out_cmd;
  logic [NO*AW-1:0] umi_out_dstaddr;
  logic [NO*AW-1:0] umi_out_srcaddr;
  logic [NO*DW-1:0] umi_out_data;
  logic [NI-1:0]    err_route;

  umi_xbar_rr #(.NI(NI), .NO(NO), .CW(CW), .AW(AW), .DW(DW), .RLSB(RLSB), .RW(RW)) dut (
    .clk(clk), .reset(reset), .mask(mask),
    .umi_in_valid(umi_in_valid), .umi_in_ready(umi_in_ready),
    .umi_in_cmd(umi_in_cmd), .umi_in_dstaddr(umi_in_dstaddr),
    .umi_in_srcaddr(umi_in_srcaddr), .umi_in_data(umi_in_data),
    .umi_out_valid(umi_out_valid), .umi_out_ready(umi_out_ready),
    .umi_out_cmd(umi_out_cmd), .umi_out_dstaddr(umi_out_dstaddr),
    .umi_out_srcaddr(umi_out_srcaddr), .umi_out_data(umi_out_data),
    .err_route(err_route)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: each output holds at most one packet and remembers which
  // input it served last; the next grant is the first requester after it.
  logic [NO-1:0]    m_vld;
  logic [NI-1:0]    m_err;
  logic [NI-1:0]    m_rdy;
  logic [NI-1:0]    m_drop;
  logic [NO*CW-1:0] m_cmd;
  logic [NO*AW-1:0] m_dst;
  logic [NO*AW-1:0] m_src;
  logic [NO*DW-1:0] m_data;
  int               m_last [NO];
  int               m_gnt  [NO];
  logic [NI-1:0]    obs_rdy;

  function automatic int route_of(int i);
    return int'(umi_in_dstaddr[i*AW+RLSB +: RW]);
  endfunction

  task automatic model_eval();
    int c;
    m_rdy  = '0;
    m_drop = '0;
    for (int j = 0; j < NO; j++) m_gnt[j] = -1;
    if (!reset) begin
      for (int i = 0; i < NI; i++)
        m_drop[i] = umi_in_valid[i] && (route_of(i) >= NO);
      for (int j = 0; j < NO; j++) begin
        if (!m_vld[j] || umi_out_ready[j]) begin
          for (int k = 1; k <= NI; k++) begin
            c = (m_last[j] + k) % NI;
            if (m_gnt[j] < 0 && umi_in_valid[c] && route_of(c) == j && !mask[j*NI+c])
              m_gnt[j] = c;
          end
        end
        if (m_gnt[j] >= 0) m_rdy[m_gnt[j]] = 1'b1;
      end
      m_rdy = m_rdy | m_drop;
    end
  endtask

  task automatic model_commit();
    int g;
    if (reset) begin
      m_vld = '0; m_err = '0; m_cmd = '0; m_dst = '0; m_src = '0; m_data = '0;
      for (int j = 0; j < NO; j++) m_last[j] = NI - 1;
    end else begin
      for (int j = 0; j < NO; j++) begin
        g = m_gnt[j];
        if (g >= 0) begin
          m_vld[j] = 1'b1;
          m_cmd[j*CW +: CW]  = umi_in_cmd[g*CW +: CW];
          m_dst[j*AW +: AW]  = umi_in_dstaddr[g*AW +: AW];
          m_src[j*AW +: AW]  = umi_in_srcaddr[g*AW +: AW];
          m_data[j*DW +: DW] = umi_in_data[g*DW +: DW];
          m_last[j] = g;
        end else if (umi_out_ready[j]) begin
          m_vld[j] = 1'b0;
        end
      end
      m_err = m_err | m_drop;
    end
  endtask

  function automatic logic [FW-1:0] dut_fields(int j);
    return {umi_out_cmd[j*CW +: CW], umi_out_dstaddr[j*AW +: AW],
            umi_out_srcaddr[j*AW +: AW], umi_out_data[j*DW +: DW]};
  endfunction

  function automatic logic [FW-1:0] mdl_fields(int j);
    return {m_cmd[j*CW +: CW], m_dst[j*AW +: AW], m_src[j*AW +: AW], m_data[j*DW +: DW]};
  endfunction

  function automatic logic [FW-1:0] in_fields(int i);
    return {umi_in_cmd[i*CW +: CW], umi_in_dstaddr[i*AW +: AW],
            umi_in_srcaddr[i*AW +: AW], umi_in_data[i*DW +: DW]};
  endfunction

  task automatic set_pkt(int i, int route);
    logic [AW-1:0] d;
    d = {$urandom, $urandom};
    d[RLSB +: RW] = RW'(route);
    umi_in_dstaddr[i*AW +: AW] = d;
    umi_in_srcaddr[i*AW +: AW] = {$urandom, $urandom};
    umi_in_cmd[i*CW +: CW]     = $urandom;
    for (int w = 0; w < DW/32; w++) umi_in_data[i*DW + w*32 +: 32] = $urandom;
    umi_in_valid[i] = 1'b1;
  endtask

  // One clock: ready sampled mid-cycle, model advanced at the edge, outputs
  // settle by #1 after the edge.
  task automatic cycle();
    @(negedge clk);
    model_eval();
    obs_rdy = umi_in_ready;
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic drain();
    umi_in_valid  = '0;
    umi_out_ready = '1;
    mask          = '0;
    repeat (2) cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mask = '0;
    umi_out_ready = '1;
    for (int i = 0; i < NI; i++) set_pkt(i, i % NO);
    repeat (2) begin
      cycle();
      checks++;
      if (obs_rdy !== '0) begin
        failures++; $display("FAIL reset_ready: got %b expected %b", obs_rdy, {NI{1'b0}});
      end
    end
    checks++;
    if ({umi_out_valid, err_route} !== '0) begin
      failures++; $display("FAIL reset_state: valid/err got %b expected 0", {umi_out_valid, err_route});
    end
    checks++;
    if ({umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} !== '0) begin
      failures++; $display("FAIL reset_fields: output fields not zero");
    end
    umi_in_valid = '0;
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_single();
    logic [FW-1:0] exp_f;
    set_pkt(2, 1);
    umi_in_cmd[2*CW +: CW]  = 32'h5;
    umi_in_data[2*DW +: DW] = 256'hAB;
    exp_f = in_fields(2);
    cycle();
    umi_in_valid = '0;
    checks++;
    if (obs_rdy !== 4'b0100 || m_rdy !== 4'b0100) begin
      failures++; $display("FAIL single_ready: got %b model %b expected 0100", obs_rdy, m_rdy);
    end
    checks++;
    if (umi_out_valid !== 4'b0010) begin
      failures++; $display("FAIL single_valid: got %b expected 0010", umi_out_valid);
    end
    checks++;
    if (dut_fields(1) !== exp_f) begin
      failures++; $display("FAIL single_fields: got %h expected %h", dut_fields(1), exp_f);
    end
    cycle();
    checks++;
    if (umi_out_valid !== 4'b0000) begin
      failures++; $display("FAIL single_unload: got %b expected 0000", umi_out_valid);
    end
  endtask

  task automatic test_contention();
    int left [NI];
    int order [3] = '{0, 1, 3};
    int sent = 0;
    int cyc = 0;
    logic [NI-1:0] exp_v;
    left = '{6, 6, 0, 6};
    umi_out_ready = '1;
    set_pkt(0, 0); set_pkt(1, 0); set_pkt(3, 0);
    while (sent < 18 && cyc < 40) begin
      cycle();
      cyc++;
      exp_v = '0;
      exp_v[order[sent % 3]] = 1'b1;
      checks++;
      if (obs_rdy !== exp_v) begin
        failures++; $display("FAIL rr_order: transfer %0d got %b expected %b", sent, obs_rdy, exp_v);
      end
      checks++;
      if (obs_rdy !== m_rdy || umi_out_valid !== m_vld || dut_fields(0) !== mdl_fields(0)) begin
        failures++; $display("FAIL rr_model: ready %b/%b valid %b/%b", obs_rdy, m_rdy, umi_out_valid, m_vld);
      end
      for (int i = 0; i < NI; i++) begin
        if (obs_rdy[i] && umi_in_valid[i]) begin
          sent++;
          left[i]--;
          if (left[i] > 0) set_pkt(i, 0);
          else umi_in_valid[i] = 1'b0;
        end
      end
    end
    checks++;
    if (cyc !== 18) begin
      failures++; $display("FAIL rr_throughput: got %0d cycles expected 18", cyc);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] pkt0, pkt1;
    umi_out_ready = 4'b1011;
    set_pkt(0, 2); set_pkt(1, 2); set_pkt(3, 2);
    pkt0 = in_fields(0);
    pkt1 = in_fields(1);
    cycle();
    umi_in_valid[0] = 1'b0;
    checks++;
    if (obs_rdy !== 4'b0001) begin
      failures++; $display("FAIL bp_first: got %b expected 0001", obs_rdy);
    end
    repeat (5) begin
      cycle();
      checks++;
      if (obs_rdy !== 4'b0000 || umi_out_valid[2] !== 1'b1 || dut_fields(2) !== pkt0) begin
        failures++; $display("FAIL bp_stall: ready %b valid %b fields %h", obs_rdy, umi_out_valid, dut_fields(2));
      end
    end
    umi_out_ready = '1;
    cycle();
    umi_in_valid[1] = 1'b0;
    checks++;
    if (obs_rdy !== 4'b0010 || umi_out_valid[2] !== 1'b1 || dut_fields(2) !== pkt1) begin
      failures++; $display("FAIL bp_release: ready %b expected 0010 fields %h", obs_rdy, dut_fields(2));
    end
    cycle();
    umi_in_valid[3] = 1'b0;
    checks++;
    if (obs_rdy !== 4'b1000 || dut_fields(2) !== mdl_fields(2)) begin
      failures++; $display("FAIL bp_next: ready %b expected 1000", obs_rdy);
    end
    drain();
  endtask

  task automatic test_out_of_range();
    set_pkt(1, 7);
    cycle();
    umi_in_valid = '0;
    checks++;
    if (obs_rdy !== 4'b0010) begin
      failures++; $display("FAIL oor_ready: got %b expected 0010", obs_rdy);
    end
    checks++;
    if (err_route !== 4'b0010 || umi_out_valid !== 4'b0000) begin
      failures++; $display("FAIL oor_err: err %b valid %b expected 0010/0000", err_route, umi_out_valid);
    end
    cycle();
    checks++;
    if (err_route !== 4'b0010) begin
      failures++; $display("FAIL oor_sticky: got %b expected 0010", err_route);
    end
  endtask

  task automatic test_mask();
    mask = '0;
    mask[3*NI+0] = 1'b1;
    set_pkt(0, 3); set_pkt(1, 2); set_pkt(2, 1);
    cycle();
    umi_in_valid[1] = 1'b0;
    umi_in_valid[2] = 1'b0;
    checks++;
    if (obs_rdy !== 4'b0110) begin
      failures++; $display("FAIL mask_parallel: got %b expected 0110", obs_rdy);
    end
    mask = '0;
    cycle();
    umi_in_valid[0] = 1'b0;
    checks++;
    if (obs_rdy !== 4'b0001 || umi_out_valid !== 4'b1000 || dut_fields(3) !== mdl_fields(3)) begin
      failures++; $display("FAIL mask_clear: ready %b valid %b expected 0001/1000", obs_rdy, umi_out_valid);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    umi_out_ready = '1;
    set_pkt(0, 0); set_pkt(1, 0); set_pkt(3, 0);
    repeat (4) begin
      cycle();
      checks++;
      if (obs_rdy !== m_rdy || umi_out_valid !== m_vld || dut_fields(0) !== mdl_fields(0)) begin
        failures++; $display("FAIL rstmid_run: ready %b/%b valid %b/%b", obs_rdy, m_rdy, umi_out_valid, m_vld);
      end
      for (int i = 0; i < NI; i++) if (obs_rdy[i]) set_pkt(i, 0);
    end
    reset = 1'b1;
    cycle();
    checks++;
    if (obs_rdy !== 4'b0000 || umi_out_valid !== 4'b0000 || err_route !== 4'b0000) begin
      failures++; $display("FAIL rstmid_clear: ready %b valid %b err %b", obs_rdy, umi_out_valid, err_route);
    end
    reset = 1'b0;
    cycle();
    checks++;
    if (obs_rdy !== 4'b0001 || m_rdy !== 4'b0001) begin
      failures++; $display("FAIL rstmid_lowest: got %b model %b expected 0001", obs_rdy, m_rdy);
    end
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < NI*NO; b++) mask[b] = ($urandom_range(0, 15) == 0);
      for (int j = 0; j < NO; j++) umi_out_ready[j] = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NI; i++)
        if (!umi_in_valid[i] && $urandom_range(0, 9) < 6) set_pkt(i, $urandom_range(0, NO + 1));
      cycle();
      checks++;
      if (obs_rdy !== m_rdy) begin
        failures++; $display("FAIL rand_ready: cycle %0d got %b expected %b", n, obs_rdy, m_rdy);
      end
      checks++;
      if ({umi_out_valid, err_route} !== {m_vld, m_err}) begin
        failures++; $display("FAIL rand_valid_err: cycle %0d got %b expected %b", n, {umi_out_valid, err_route}, {m_vld, m_err});
      end
      for (int j = 0; j < NO; j++) begin
        checks++;
        if (dut_fields(j) !== mdl_fields(j)) begin
          failures++; $display("FAIL rand_fields%0d: got %h expected %h", j, dut_fields(j), mdl_fields(j));
        end
      end
      umi_in_valid = umi_in_valid & ~obs_rdy;
    end
    drain();
  endtask

  initial begin
    reset          = 1'b1;
    mask           = '0;
    umi_in_valid   = '0;
    umi_in_cmd     = '0;
    umi_in_dstaddr = '0;
    umi_in_srcaddr = '0;
    umi_in_data    = '0;
    umi_out_ready  = '1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_out_of_range();
    test_mask();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
